io_pad_arbiter: RTL and testbench

- Shares one muxable IO pad between REQUESTERS independent clients by driving the pad's function-select input.
- Round-robin arbitration; a grant is held until the owner releases it or is pre-empted.
- Every ownership change passes through a guaranteed high-Z turnaround, with func_select = 0 (no function / pad released), so two functions never drive the pin back-to-back.
- Sits between client logic and the pad mux; one instance per shared pad.

---
 rtl/io_pad_arbiter.sv | 171 +++++++++++++++++
 tb/tb_io_pad_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_pad_arbiter.sv
// Round-robin owner arbitration for one shared muxable IO pad.
// Every hand-over passes through IDLE plus a zero-select turnaround so two pad functions never drive back-to-back.
`timescale 1ns/1ps
module io_pad_arbiter #(
   parameter int unsigned REQUESTERS = 4,
   parameter int unsigned MUXWIDTH   = 3,
   parameter int unsigned TURNAROUND = 2,
   parameter int unsigned MAX_HOLD   = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [REQUESTERS-1:0]            req,
   input  logic [REQUESTERS*MUXWIDTH-1:0]   req_func,
   output logic [REQUESTERS-1:0]            grant,
   output logic [MUXWIDTH-1:0]              func_select,
   output logic                             busy,
   output logic                             preempt
);

   localparam int unsigned IDX_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam int unsigned TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
   localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(REQUESTERS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TURN,
      ST_OWNED
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        winner_q, winner_d;
   logic [MUXWIDTH-1:0]     func_q, func_d;
   logic [TURN_W-1:0]       turn_q, turn_d;
   logic [HOLD_W-1:0]       hold_q, hold_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [REQUESTERS-1:0]   grant_q, grant_d;
   logic [MUXWIDTH-1:0]     func_sel_q, func_sel_d;
   logic                    busy_q, busy_d;
   logic                    preempt_q, preempt_d;

   logic                    revoke;
   logic                    pick_found;
   logic [IDX_W-1:0]        pick_idx;
   logic [IDX_W-1:0]        pick_k;
   logic [IDX_W-1:0]        next_ptr;
   logic [REQUESTERS-1:0]   winner_oh;
   logic                    others_req;
   logic [MUXWIDTH-1:0]     func_arr [REQUESTERS];

   always_comb begin
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         func_arr[i] = req_func[i*MUXWIDTH +: MUXWIDTH];
      end
   end

   // First requester at or above rr_ptr, wrapping; the previous owner therefore ranks last.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = rr_ptr_q;
      pick_k     = '0;
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         pick_k = IDX_W'((32'(rr_ptr_q) + i) % REQUESTERS);
         if (!pick_found && req[pick_k]) begin
            pick_found = 1'b1;
            pick_idx   = pick_k;
         end
      end
   end

   always_comb begin
      winner_oh           = '0;
      winner_oh[winner_q] = 1'b1;
      others_req          = |(req & ~winner_oh);
      next_ptr            = (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         winner_q   <= '0;
         func_q     <= '0;
         turn_q     <= '0;
         hold_q     <= '0;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         func_sel_q <= '0;
         busy_q     <= 1'b0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         func_q     <= func_d;
         turn_q     <= turn_d;
         hold_q     <= hold_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         func_sel_q <= func_sel_d;
         busy_q     <= busy_d;
         preempt_q  <= preempt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      func_d   = func_q;
      turn_d   = turn_q;
      hold_d   = hold_q;
      rr_ptr_d = rr_ptr_q;
      revoke   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            hold_d = '0;
            if (pick_found) begin
               winner_d = pick_idx;
               func_d   = func_arr[pick_idx];
               turn_d   = TURN_LOAD;
               state_d  = ST_TURN;
            end
         end
         ST_TURN: begin
            hold_d = '0;
            if (!req[winner_q]) begin
               state_d = ST_IDLE;
            end else if (turn_q == '0) begin
               state_d = ST_OWNED;
            end else begin
               turn_d = turn_q - 1'b1;
            end
         end
         ST_OWNED: begin
            // Release wins over a coincident timeout, so preempt only fires while req is still held.
            if (!req[winner_q]) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_req) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
               revoke   = 1'b1;
            end else if (hold_q != HOLD_LAST) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register in step with state_q.
   always_comb begin
      grant_d    = '0;
      func_sel_d = '0;
      busy_d     = (state_d != ST_IDLE);
      preempt_d  = revoke;
      if (state_d == ST_OWNED) begin
         grant_d[winner_d] = 1'b1;
         func_sel_d        = func_d;
      end
   end

   assign grant       = grant_q;
   assign func_select = func_sel_q;
   assign busy        = busy_q;
   assign preempt     = preempt_q;

endmodule

// File: tb/tb_io_pad_arbiter.sv
// Scoreboard bench for io_pad_arbiter: two instances (with/without pre-emption) share one stimulus stream
// and are compared cycle by cycle against an ownership-level reference model.
`timescale 1ns/1ps
module tb_io_pad_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [11:0] req_func = '0;

   logic [3:0]  grant_a, grant_b;
   logic [2:0]  fsel_a, fsel_b;
   logic        busy_a, busy_b, pre_a, pre_b;

   always #5 clk = ~clk;

   io_pad_arbiter #(.REQUESTERS(4), .MUXWIDTH(3), .TURNAROUND(2), .MAX_HOLD(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .req_func(req_func),
      .grant(grant_a), .func_select(fsel_a), .busy(busy_a), .preempt(pre_a)
   );

   io_pad_arbiter #(.REQUESTERS(4), .MUXWIDTH(3), .TURNAROUND(1), .MAX_HOLD(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .req_func(req_func),
      .grant(grant_b), .func_select(fsel_b), .busy(busy_b), .preempt(pre_b)
   );

   typedef struct packed {
      logic [3:0] g;
      logic [2:0] f;
      logic       b;
      logic       p;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   // Reference model: who owns the pad, who is waiting out the turnaround, and for how long.
   int         tt [2] = '{2, 1};
   int         mh [2] = '{8, 0};
   int         m_owner [2];
   int         m_cand [2];
   int         m_wait [2];
   int         m_held [2];
   int         m_ptr [2];
   logic [2:0] m_func [2];
   logic       m_pre [2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = -1;
         m_cand[d]  = -1;
         m_wait[d]  = 0;
         m_held[d]  = 0;
         m_ptr[d]   = 0;
         m_func[d]  = '0;
         m_pre[d]   = 1'b0;
      end
   endtask

   task automatic model_edge(input int d, input logic [3:0] r, input logic [11:0] f, output exp_t e);
      logic [3:0] others;
      logic       found;
      int         c;
      m_pre[d] = 1'b0;
      if (m_owner[d] >= 0) begin
         others = r & ~(4'b0001 << m_owner[d]);
         if (!r[m_owner[d]]) begin
            m_ptr[d]   = (m_owner[d] + 1) % 4;
            m_owner[d] = -1;
         end else if (mh[d] != 0 && m_held[d] >= mh[d] - 1 && others != 0) begin
            m_pre[d]   = 1'b1;
            m_ptr[d]   = (m_owner[d] + 1) % 4;
            m_owner[d] = -1;
         end else begin
            m_held[d]++;
         end
      end else if (m_cand[d] >= 0) begin
         if (!r[m_cand[d]]) begin
            m_cand[d] = -1;
         end else if (m_wait[d] == 0) begin
            m_owner[d] = m_cand[d];
            m_cand[d]  = -1;
            m_held[d]  = 0;
         end else begin
            m_wait[d]--;
         end
      end else if (r != 0) begin
         found = 1'b0;
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr[d] + k) % 4;
            if (!found && r[c]) begin
               found     = 1'b1;
               m_cand[d] = c;
               m_func[d] = f[c*3 +: 3];
            end
         end
         m_wait[d] = tt[d] - 1;
      end
      e.g = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
      e.f = (m_owner[d] >= 0) ? m_func[d] : 3'd0;
      e.b = (m_owner[d] >= 0) || (m_cand[d] >= 0);
      e.p = m_pre[d];
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Called between edges with inputs already applied; queues the expected post-edge outputs.
   task automatic step(input int n);
      exp_t ea, eb;
      repeat (n) begin
         model_edge(0, req, req_func, ea);
         model_edge(1, req, req_func, eb);
         q_a.push_back(ea);
         q_b.push_back(eb);
         @(posedge clk);
         #2;
      end
   endtask

   // Asserts reset half-way between edges and checks the outputs fall without a clock.
   task automatic do_reset();
      chk_en = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      cmp("rst_grant_a", 32'(grant_a), 0);
      cmp("rst_fsel_a",  32'(fsel_a), 0);
      cmp("rst_busy_a",  32'(busy_a), 0);
      cmp("rst_pre_a",   32'(pre_a), 0);
      cmp("rst_grant_b", 32'(grant_b), 0);
      cmp("rst_fsel_b",  32'(fsel_b), 0);
      cmp("rst_busy_b",  32'(busy_b), 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      q_a.delete();
      q_b.delete();
      model_reset();
      rst_n  = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (chk_en) begin
            if (q_a.size() == 0) begin
               cmp("queue_a_empty", 32'(q_a.size()), 1);
            end else begin
               e = q_a.pop_front();
               cmp("grant_a",   32'(grant_a), 32'(e.g));
               cmp("fsel_a",    32'(fsel_a),  32'(e.f));
               cmp("busy_a",    32'(busy_a),  32'(e.b));
               cmp("preempt_a", 32'(pre_a),   32'(e.p));
            end
            if (q_b.size() == 0) begin
               cmp("queue_b_empty", 32'(q_b.size()), 1);
            end else begin
               e = q_b.pop_front();
               cmp("grant_b",   32'(grant_b), 32'(e.g));
               cmp("fsel_b",    32'(fsel_b),  32'(e.f));
               cmp("busy_b",    32'(busy_b),  32'(e.b));
               cmp("preempt_b", 32'(pre_b),   32'(e.p));
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      model_reset();
      @(posedge clk);
      #2;

      // single client, func 3
      do_reset();
      req_func = 12'd3;
      req = 4'b0001;
      step(6);
      req = 4'b0000;
      step(3);

      // simultaneous 1 and 3 from reset; client 0 carries func 0
      do_reset();
      req_func = {3'd7, 3'd6, 3'd2, 3'd0};
      req = 4'b1010;
      step(6);
      req = 4'b1000;
      step(8);
      req = 4'b0000;
      step(3);

      // client 0 releases and re-requests while client 2 waits
      req = 4'b0001;
      step(4);
      req = 4'b0101;
      step(3);
      req = 4'b0100;
      step(1);
      req = 4'b0101;
      step(10);
      req = 4'b0000;
      step(3);

      // long ownership with a waiter: timeout only where enabled
      req = 4'b0001;
      step(4);
      req = 4'b0011;
      step(20);
      req = 4'b0000;
      step(3);

      // winner abandons during turnaround
      req = 4'b0100;
      step(1);
      req = 4'b0000;
      step(4);

      // async reset while owned, then arbitration restarts from client 0
      req_func = {3'd4, 3'd5, 3'd1, 3'd6};
      req = 4'b0100;
      step(5);
      do_reset();
      req = 4'b1111;
      step(6);
      req = 4'b0000;
      step(2);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(5) == 0) req[i] = ~req[i];
         end
         req_func = 12'($urandom);
         step(1);
         if (n == 700) do_reset();
      end
      req = 4'b0000;
      step(2);

      chk_en = 1'b0;
      cmp("queue_a_drain", 32'(q_a.size()), 0);
      cmp("queue_b_drain", 32'(q_b.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
